imm_extend_stage: RTL and testbench

IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

---
 rtl/imm_ext_pkg.sv | 10 +
 rtl/imm_ext_core.sv | 41 ++++
 rtl/imm_extend_stage.sv | 92 +++++++++
 tb/tb_imm_extend_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline stage.
// The 2-bit encodings select how a raw immediate is widened.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Purely combinational immediate widening: sign, zero, upper-placed
// or sign-extended branch offset scaled by 2**SHIFT_BR.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int SHIFT_BR = 2
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    zext                = '0;
    zext[IN_W-1:0]      = in_data;
    sext                = zext;
    for (int i = IN_W; i < OUT_W; i++) begin
      sext[i] = in_data[IN_W-1];
    end
    upper               = '0;
    upper[OUT_W-1 -: IN_W] = in_data;

    ext = sext;
    case (mode)
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = zext;
      MODE_UPPER:  ext = upper;
      MODE_BRANCH: ext = sext << SHIFT_BR;
      default:     ext = sext;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_extend_stage.sv
// Valid/ready pipeline stage around imm_ext_core: the extension is
// captured at acceptance into a two-entry skid buffer (main + skid).
module imm_extend_stage #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int SHIFT_BR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  logic [OUT_W-1:0] ext;
  logic             accept;
  logic             drain;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_BR(SHIFT_BR)
  ) u_core (
    .in_data(in_data),
    .mode   (in_mode),
    .ext    (ext)
  );

  // in_ready comes straight from the skid flag, so out_ready never
  // reaches it combinationally.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign drain     = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_neg   = main_data_q[OUT_W-1];

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (drain) begin
      if (skid_valid_q) begin
        // Skid full means in_ready is low, so nothing new arrives here.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = ext;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = ext;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ext;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      // NOTE: the data registers are cleared too, because out_data must
      // read zero after reset rather than whatever was last held.
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule : imm_extend_stage

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed vectors, stall and
// reset sequences, and a randomized run against a queue-based model.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_neg;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_out_neg;
  logic [11:0] p_in_data;
  logic [1:0]  p_in_mode;
  logic [31:0] p_out_data;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imm_extend_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_neg  (out_neg)
  );

  imm_extend_stage #(.IN_W(12), .OUT_W(32), .SHIFT_BR(2)) dut_p (
    .clk      (clk),
    .rst      (rst),
    .in_valid (p_in_valid),
    .in_ready (p_in_ready),
    .in_data  (p_in_data),
    .in_mode  (p_in_mode),
    .out_valid(p_out_valid),
    .out_ready(p_out_ready),
    .out_data (p_out_data),
    .out_neg  (p_out_neg)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] exp;
    logic        neg;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: value of the immediate as a signed/unsigned integer, then
  // placed, scaled and truncated to 32 bits by plain arithmetic.
  function automatic logic [31:0] ref_ext(input int in_w, input logic [31:0] raw,
                                          input logic [1:0] mode);
    longint one = 1;
    longint u   = longint'(raw) & ((one << in_w) - 1);
    longint s   = (u >= (one << (in_w - 1))) ? u - (one << in_w) : u;
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * (one << (32 - in_w)));
      default: return 32'(s * 4);
    endcase
  endfunction

  logic [31:0] model_q[$];
  logic [31:0] exp_a, exp_b, exp_c;
  bit          acc, drn;

  initial begin
    vecs[0] = '{2'd0, 16'h00FF, 32'h000000FF, 1'b0};
    vecs[1] = '{2'd0, 16'h8000, 32'hFFFF8000, 1'b1};
    vecs[2] = '{2'd1, 16'h8000, 32'h00008000, 1'b0};
    vecs[3] = '{2'd2, 16'h1234, 32'h12340000, 1'b0};
    vecs[4] = '{2'd3, 16'hFFFF, 32'hFFFFFFFC, 1'b1};
    vecs[5] = '{2'd3, 16'h0004, 32'h00000010, 1'b0};

    rst = 1'b1; in_valid = 1'b1; in_data = 16'h8000; in_mode = 2'd0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_in_mode = 2'd0; p_out_ready = 1'b1;

    // Reset, with in_valid asserted to show it is ignored
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_neg",   32'(out_neg), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("post_rst_idle_valid", 32'(out_valid), 32'd0);

    // Directed mode vectors, one cycle latency each
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].data;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_neg", i), 32'(out_neg), 32'(vecs[i].neg));
    end
    @(posedge clk); #1;
    check("vec_drained", 32'(out_valid), 32'd0);

    // Parameter override instance
    @(negedge clk); p_in_valid = 1'b1; p_in_mode = 2'd0; p_in_data = 12'h800;
    @(posedge clk); #1;
    check("p_sign_data", p_out_data, 32'hFFFFF800);
    check("p_sign_neg",  32'(p_out_neg), 32'd1);
    @(negedge clk); p_in_mode = 2'd2; p_in_data = 12'hABC;
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    check("p_upper_data", p_out_data, 32'hABC00000);

    // Stall: A, B, C offered back-to-back with out_ready low
    exp_a = ref_ext(16, 32'h8001, 2'd0);
    exp_b = ref_ext(16, 32'h4001, 2'd3);
    exp_c = ref_ext(16, 32'h00F0, 2'd2);
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_data = 16'h8001;
    @(posedge clk); #1;
    check("stall_a_valid", 32'(out_valid), 32'd1);
    check("stall_a_data",  out_data, exp_a);
    check("stall_a_ready", 32'(in_ready), 32'd1);
    @(negedge clk); in_mode = 2'd3; in_data = 16'h4001;
    @(posedge clk); #1;
    check("stall_b_ready_low", 32'(in_ready), 32'd0);
    check("stall_a_hold1", out_data, exp_a);
    @(negedge clk); in_mode = 2'd2; in_data = 16'h00F0;
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_c_ready_low", 32'(in_ready), 32'd0);
      check("stall_a_hold", out_data, exp_a);
      check("stall_valid_hold", 32'(out_valid), 32'd1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_out_b", out_data, exp_b);
    check("stall_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_out_c", out_data, exp_c);
    check("stall_c_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("stall_empty", 32'(out_valid), 32'd0);

    // Full throughput: 8 items on 8 consecutive cycles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'($urandom_range(0, 3)); in_data = 16'($urandom);
      check($sformatf("tput%0d_in_ready", i), 32'(in_ready), 32'd1);
      exp_a = ref_ext(16, 32'(in_data), in_mode);
      @(posedge clk); #1;
      check($sformatf("tput%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("tput%0d_data", i), out_data, exp_a);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("tput_drained", 32'(out_valid), 32'd0);

    // Reset with both entries full
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_data = 16'hF00D;
    @(posedge clk);
    @(negedge clk); in_data = 16'hBEEF;
    @(posedge clk); #1;
    check("full_before_rst", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  out_data, 32'd0);
    check("midrst_out_neg",   32'(out_neg), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic against an order-preserving two-deep queue model
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      acc = in_valid && (model_q.size() < 2);
      drn = out_ready && (model_q.size() > 0);
      @(posedge clk);
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(ref_ext(16, 32'(in_data), in_mode));
      #1;
      check("rnd_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
      check("rnd_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("rnd_out_data", out_data, model_q[0]);
        check("rnd_out_neg", 32'(out_neg), 32'(model_q[0][31]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_imm_extend_stage
